register_file: RTL and testbench

- 2-read / 1-write general-purpose register file for the MIPS datapath; sits between decode (read ports) and writeback (write port).
- The write side is the inverse of the operand-select muxes: a one-hot decoder distributes a single write value to exactly one of N registers.
- Register 0 is hardwired to zero.
- Write-through bypass lets a same-cycle writeback feed decode without a stall.

---
 rtl/register_file_pkg.sv | 10 +
 rtl/register_file_write_decoder.sv | 20 ++
 rtl/register_file.sv | 81 ++++++++
 tb/tb_register_file.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared widths and MIPS register-index constants for the register file slice.
// Data/address widths here are the defaults picked up by register_file and its decoder.
package register_file_pkg;
  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/register_file_write_decoder.sv
// One-hot write-enable decoder: demux counterpart of the operand-select muxes.
// Purely combinational; bit 0 never asserts because register 0 is hardwired to zero.
module reg_write_decoder
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                       en,
  input  logic [ADDR_WIDTH-1:0]      addr,
  output logic [2**ADDR_WIDTH-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en && (addr != '0)) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/register_file.sv
// 2-read/1-write MIPS register file with r0 hardwired to zero and write-through bypass.
// Reads are combinational (0 cycles), writes land at the next rising edge; no back-pressure.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr0,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [DATA_WIDTH-1:0] rd_data0,
  output logic [DATA_WIDTH-1:0] rd_data1,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      wr_onehot;
  logic                  wr_live;
  logic                  byp0;
  logic                  byp1;

  // Reset suppresses the decoder so a colliding write can neither store nor bypass.
  assign wr_live = wr_en && !rst;

  reg_write_decoder #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wr_dec (
    .en    (wr_live),
    .addr  (wr_addr),
    .onehot(wr_onehot)
  );

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      regs_d[k] = wr_onehot[k] ? wr_data : regs_q[k];
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  assign byp0 = wr_live && (wr_addr != '0) && (rd_addr0 == wr_addr);
  assign byp1 = wr_live && (wr_addr != '0) && (rd_addr1 == wr_addr);

  // r0 is forced on the read side too, so it reads zero even before the first reset.
  always_comb begin
    if (rd_addr0 == '0) begin
      rd_data0 = '0;
    end else if (byp0) begin
      rd_data0 = wr_data;
    end else begin
      rd_data0 = regs_q[rd_addr0];
    end

    if (rd_addr1 == '0) begin
      rd_data1 = '0;
    end else if (byp1) begin
      rd_data1 = wr_data;
    end else begin
      rd_data1 = regs_q[rd_addr1];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, write/read, r0, bypass, reset collision, back-to-back.
module tb_register_file;
  import register_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr0, rd_addr1, wr_addr;
  logic [31:0] rd_data0, rd_data1, wr_data;
  logic        wr_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr0(rd_addr0),
    .rd_addr1(rd_addr1),
    .rd_data0(rd_data0),
    .rd_data1(rd_data1),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    do_write(5'd5, 32'h0000_1234);
    do_write(5'd31, 32'hFFFF_FFFF);
    rd_addr0 = 5'd5; rd_addr1 = 5'd31; #1;
    checks++;
    if (rd_data0 !== 32'h0000_1234) begin
      errors++; $display("FAIL preload_r5 got=%h exp=%h", rd_data0, 32'h0000_1234);
    end
    checks++;
    if (rd_data1 !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL preload_r31 got=%h exp=%h", rd_data1, 32'hFFFF_FFFF);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr0 = a[4:0]; rd_addr1 = 5'(31 - a); #1;
      checks++;
      if (rd_data0 !== 32'h0) begin
        errors++; $display("FAIL reset_rd0 addr=%0d got=%h exp=0", a, rd_data0);
      end
      checks++;
      if (rd_data1 !== 32'h0) begin
        errors++; $display("FAIL reset_rd1 addr=%0d got=%h exp=0", 31 - a, rd_data1);
      end
    end
  endtask

  task automatic test_basic_write();
    do_write(5'd7, 32'hDEAD_BEEF);
    rd_addr0 = 5'd7; rd_addr1 = 5'd7; #1;
    checks++;
    if (rd_data0 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL basic_rd0 got=%h exp=%h", rd_data0, 32'hDEAD_BEEF);
    end
    checks++;
    if (rd_data1 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL basic_rd1 got=%h exp=%h", rd_data1, 32'hDEAD_BEEF);
    end
    rd_addr0 = 5'd6; rd_addr1 = 5'd8; #1;
    checks++;
    if (rd_data0 !== 32'h0) begin
      errors++; $display("FAIL basic_r6 got=%h exp=0", rd_data0);
    end
    checks++;
    if (rd_data1 !== 32'h0) begin
      errors++; $display("FAIL basic_r8 got=%h exp=0", rd_data1);
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = REG_ZERO; wr_data = 32'hAAAA_AAAA;
    rd_addr0 = REG_ZERO; rd_addr1 = REG_ZERO; #1;
    checks++;
    if (rd_data0 !== 32'h0) begin
      errors++; $display("FAIL zero_same_cycle got=%h exp=0", rd_data0);
    end
    checks++;
    if (dut.wr_onehot !== 32'h0) begin
      errors++; $display("FAIL zero_decoder got=%h exp=0", dut.wr_onehot);
    end
    tick();
    wr_en = 1'b0; #1;
    checks++;
    if (rd_data0 !== 32'h0) begin
      errors++; $display("FAIL zero_after_edge got=%h exp=0", rd_data0);
    end
    // Decoder one-hot for a normal write
    wr_en = 1'b1; wr_addr = 5'd12; #1;
    checks++;
    if (dut.wr_onehot !== 32'h0000_1000) begin
      errors++; $display("FAIL decoder_onehot got=%h exp=%h", dut.wr_onehot, 32'h0000_1000);
    end
    wr_en = 1'b0; #1;
  endtask

  task automatic test_bypass();
    do_write(5'd3, 32'h11);
    do_write(5'd4, 32'h44);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h22;
    rd_addr0 = 5'd3; rd_addr1 = 5'd4; #1;
    checks++;
    if (rd_data0 !== 32'h22) begin
      errors++; $display("FAIL bypass_rd0 got=%h exp=%h", rd_data0, 32'h22);
    end
    checks++;
    if (rd_data1 !== 32'h44) begin
      errors++; $display("FAIL bypass_rd1_other got=%h exp=%h", rd_data1, 32'h44);
    end
    tick();
    wr_en = 1'b0; #1;
    checks++;
    if (rd_data0 !== 32'h22) begin
      errors++; $display("FAIL bypass_after_edge got=%h exp=%h", rd_data0, 32'h22);
    end
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h77;
    rd_addr0 = 5'd10; rd_addr1 = 5'd10; #1;
    checks++;
    if (rd_data0 !== 32'h77) begin
      errors++; $display("FAIL bypass_dual_rd0 got=%h exp=%h", rd_data0, 32'h77);
    end
    checks++;
    if (rd_data1 !== 32'h77) begin
      errors++; $display("FAIL bypass_dual_rd1 got=%h exp=%h", rd_data1, 32'h77);
    end
    wr_en = 1'b0; #1;
    checks++;
    if (rd_data0 !== 32'h0) begin
      errors++; $display("FAIL bypass_no_wr_en got=%h exp=0", rd_data0);
    end
  endtask

  task automatic test_reset_collision();
    do_write(5'd9, 32'h99);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    rd_addr0 = 5'd9; rd_addr1 = 5'd3; #1;
    checks++;
    if (rd_data0 !== 32'h99) begin
      errors++; $display("FAIL rstcol_no_bypass got=%h exp=%h", rd_data0, 32'h99);
    end
    tick();
    rst = 1'b0; wr_en = 1'b0; #1;
    checks++;
    if (rd_data0 !== 32'h0) begin
      errors++; $display("FAIL rstcol_r9 got=%h exp=0", rd_data0);
    end
    checks++;
    if (rd_data1 !== 32'h0) begin
      errors++; $display("FAIL rstcol_r3 got=%h exp=0", rd_data1);
    end
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_addr = REG_RA; wr_data = 32'd1;
    rd_addr1 = REG_RA; rd_addr0 = REG_SP; #1;
    checks++;
    if (rd_data1 !== 32'd1) begin
      errors++; $display("FAIL b2b_cycle1 got=%h exp=1", rd_data1);
    end
    tick();
    wr_data = 32'd2; #1;
    checks++;
    if (rd_data1 !== 32'd2) begin
      errors++; $display("FAIL b2b_cycle2 got=%h exp=2", rd_data1);
    end
    checks++;
    if (dut.regs_q[31] !== 32'd1) begin
      errors++; $display("FAIL b2b_stored1 got=%h exp=1", dut.regs_q[31]);
    end
    tick();
    wr_en = 1'b0; #1;
    checks++;
    if (rd_data1 !== 32'd2) begin
      errors++; $display("FAIL b2b_after got=%h exp=2", rd_data1);
    end
    checks++;
    if (rd_data0 !== 32'h0) begin
      errors++; $display("FAIL b2b_sp_untouched got=%h exp=0", rd_data0);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr0 = '0; rd_addr1 = '0;
    tick();
    rst = 1'b0;
    test_reset();
    test_basic_write();
    test_zero_reg();
    test_bypass();
    test_reset_collision();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
